issue_scheduler: RTL and testbench

Out-of-order issue scheduler for the instruction buffer. It allocates buffer slots to incoming instructions and stores each slot's dependency vector, produced by the dependency table for that slot. Each cycle it picks one dependency-free, not-yet-issued slot round-robin and offers it to the execution stage. When a slot completes, it retires that slot and clears its column from every other slot's dependency vector.

---
 rtl/issue_scheduler_if.sv | 29 ++
 rtl/issue_scheduler.sv | 125 ++++++++++++
 tb/tb_issue_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/issue_scheduler_if.sv
// Handshake bundle between the issue scheduler and its allocate/issue/complete neighbours.
// The slave modport is the scheduler's view; master is the surrounding pipeline.
interface issue_scheduler_if #(
    parameter int unsigned bs = 16
) ();
    localparam int unsigned bs_bits = $clog2(bs);

    logic               alloc_valid;
    logic               alloc_ready;
    logic [bs-1:0]      alloc_dep;
    logic [bs_bits-1:0] alloc_idx;
    logic               issue_valid;
    logic               issue_ready;
    logic [bs_bits-1:0] issue_idx;
    logic               cmpl_valid;
    logic [bs_bits-1:0] cmpl_idx;
    logic               flush;
    logic [bs_bits:0]   occupancy;

    modport slave (
        input  alloc_valid, alloc_dep, issue_ready, cmpl_valid, cmpl_idx, flush,
        output alloc_ready, alloc_idx, issue_valid, issue_idx, occupancy
    );

    modport master (
        output alloc_valid, alloc_dep, issue_ready, cmpl_valid, cmpl_idx, flush,
        input  alloc_ready, alloc_idx, issue_valid, issue_idx, occupancy
    );
endinterface

// File: rtl/issue_scheduler.sv
// Out-of-order issue scheduler: allocates buffer slots, tracks per-slot dependency vectors,
// issues one ready slot per cycle round-robin and retires slots on completion.
module issue_scheduler #(
    parameter int unsigned bs = 16
) (
    input logic              clk,
    input logic              rst,
    issue_scheduler_if.slave bus
);
    localparam int unsigned bs_bits = $clog2(bs);

    typedef logic [bs-1:0]      vec_t;
    typedef logic [bs_bits-1:0] idx_t;
    typedef logic [bs_bits:0]   occ_t;

    vec_t                 valid_q, valid_d;
    vec_t                 issued_q, issued_d;
    logic [bs-1:0][bs-1:0] dep_q, dep_d;
    idx_t                 rr_q, rr_d;
    logic                 issue_valid_q, issue_valid_d;
    idx_t                 issue_idx_q, issue_idx_d;
    occ_t                 occ_q, occ_d;

    vec_t ready;
    vec_t cmpl_oh, alloc_oh;
    idx_t alloc_idx, pick_idx, cand;
    logic pick_found, alloc_ready, alloc_fire, cmpl_hit, load;

    always_comb begin
        ready = valid_q & ~issued_q;
        for (int k = 0; k < int'(bs); k++) begin
            if (dep_q[k] != '0) ready[k] = 1'b0;
        end

        alloc_idx = '0;
        for (int k = int'(bs) - 1; k >= 0; k--) begin
            if (!valid_q[k]) alloc_idx = idx_t'(k);
        end

        // Round-robin search starting at rr; index arithmetic wraps because bs is a power of two.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < int'(bs); i++) begin
            cand = rr_q + idx_t'(i);
            if (!pick_found && ready[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign alloc_ready = ~&valid_q;
    assign alloc_fire  = bus.alloc_valid & alloc_ready;
    assign cmpl_hit    = bus.cmpl_valid & valid_q[bus.cmpl_idx] & issued_q[bus.cmpl_idx];
    assign cmpl_oh     = cmpl_hit ? (vec_t'(1) << bus.cmpl_idx) : '0;
    assign alloc_oh    = vec_t'(1) << alloc_idx;
    assign load        = !issue_valid_q || bus.issue_ready;

    always_comb begin
        valid_d       = valid_q & ~cmpl_oh;
        issued_d      = issued_q & ~cmpl_oh;
        rr_d          = rr_q;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;
        for (int k = 0; k < int'(bs); k++) begin
            dep_d[k] = dep_q[k] & ~cmpl_oh;
        end

        // Same-cycle completion wins over the incoming dependency bit.
        if (alloc_fire) begin
            valid_d          = valid_d | alloc_oh;
            issued_d         = issued_d & ~alloc_oh;
            dep_d[alloc_idx] = bus.alloc_dep & valid_q & ~alloc_oh & ~cmpl_oh;
        end

        if (load) begin
            issue_valid_d = pick_found;
            if (pick_found) begin
                issue_idx_d = pick_idx;
                issued_d    = issued_d | (vec_t'(1) << pick_idx);
                rr_d        = pick_idx + idx_t'(1);
            end
        end

        if (bus.flush) begin
            valid_d       = '0;
            issued_d      = '0;
            dep_d         = '0;
            issue_valid_d = 1'b0;
            rr_d          = rr_q;
        end

        occ_d = '0;
        for (int k = 0; k < int'(bs); k++) begin
            occ_d = occ_d + occ_t'(valid_d[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q       <= '0;
            issued_q      <= '0;
            dep_q         <= '0;
            rr_q          <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            occ_q         <= '0;
        end else begin
            valid_q       <= valid_d;
            issued_q      <= issued_d;
            dep_q         <= dep_d;
            rr_q          <= rr_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            occ_q         <= occ_d;
        end
    end

    assign bus.alloc_ready = alloc_ready;
    assign bus.alloc_idx   = alloc_idx;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_idx   = issue_idx_q;
    assign bus.occupancy   = occ_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler with bs=4; issue handshakes are checked against a queue
// of expected slot indices filled as each scenario is driven.
module tb_issue_scheduler;
    localparam int unsigned bs = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    issue_scheduler_if #(.bs(bs)) bus ();

    issue_scheduler #(.bs(bs)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Called at a falling edge after inputs are driven; a handshake visible now completes at
    // the coming rising edge, so the offered slot is scored against the queue head.
    task automatic tick();
        logic [31:0] e;
        #1;
        if (bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 32'hffff_ffff;
            check("issue_idx", 32'(bus.issue_idx), e);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alloc_valid = 1'b0;
        bus.alloc_dep   = '0;
        bus.issue_ready = 1'b0;
        bus.cmpl_valid  = 1'b0;
        bus.cmpl_idx    = '0;
        bus.flush       = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_alloc_ready", 32'(bus.alloc_ready), 1);
        check("rst_alloc_idx",   32'(bus.alloc_idx), 0);
        check("rst_issue_valid", 32'(bus.issue_valid), 0);
        check("rst_occupancy",   32'(bus.occupancy), 0);

        // Independent allocation, execution stage stalled
        bus.alloc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fill_alloc_idx", 32'(bus.alloc_idx), 32'(i));
            check("fill_alloc_ready", 32'(bus.alloc_ready), 1);
            tick();
        end
        bus.alloc_valid = 1'b0;
        check("full_alloc_ready", 32'(bus.alloc_ready), 0);
        check("full_occupancy", 32'(bus.occupancy), 4);
        check("full_issue_valid", 32'(bus.issue_valid), 1);
        check("full_issue_idx", 32'(bus.issue_idx), 0);
        bus.alloc_valid = 1'b1;
        tick();
        bus.alloc_valid = 1'b0;
        tick();
        check("drop_occupancy", 32'(bus.occupancy), 4);
        check("hold_issue_valid", 32'(bus.issue_valid), 1);
        check("hold_issue_idx", 32'(bus.issue_idx), 0);

        // Round-robin issue
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
        bus.issue_ready = 1'b1;
        repeat (4) tick();
        check("rr_drained_issue_valid", 32'(bus.issue_valid), 0);
        bus.cmpl_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.cmpl_idx = 2'(i);
            tick();
        end
        bus.cmpl_valid = 1'b0;
        check("retire_all_occupancy", 32'(bus.occupancy), 0);

        // Dependency chain
        exp_q.push_back(0);
        bus.alloc_valid = 1'b1;
        bus.alloc_dep   = 4'b0000;
        tick();
        bus.alloc_dep = 4'b0001;
        check("chain_alloc_idx", 32'(bus.alloc_idx), 1);
        tick();
        bus.alloc_valid = 1'b0;
        bus.alloc_dep   = '0;
        check("chain_issue0_valid", 32'(bus.issue_valid), 1);
        check("chain_issue0_idx", 32'(bus.issue_idx), 0);
        tick();
        check("chain_blocked", 32'(bus.issue_valid), 0);
        bus.cmpl_valid = 1'b1;
        bus.cmpl_idx   = 2'd1;
        tick();
        check("unissued_cmpl_ignored", 32'(bus.occupancy), 2);
        check("still_blocked", 32'(bus.issue_valid), 0);
        bus.cmpl_idx = 2'd0;
        tick();
        bus.cmpl_valid = 1'b0;
        check("chain_occupancy", 32'(bus.occupancy), 1);
        check("chain_not_yet", 32'(bus.issue_valid), 0);
        exp_q.push_back(1);
        tick();
        check("chain_issue1_valid", 32'(bus.issue_valid), 1);
        check("chain_issue1_idx", 32'(bus.issue_idx), 1);
        tick();
        check("chain_done", 32'(bus.issue_valid), 0);
        bus.cmpl_valid = 1'b1;
        bus.cmpl_idx   = 2'd1;
        tick();
        bus.cmpl_valid = 1'b0;
        check("chain_empty", 32'(bus.occupancy), 0);

        // Simultaneous completion and allocation (rr now starts at slot 2)
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        bus.alloc_valid = 1'b1;
        repeat (3) tick();
        bus.alloc_valid = 1'b0;
        repeat (2) tick();
        check("sim_idle", 32'(bus.issue_valid), 0);
        check("sim_occupancy", 32'(bus.occupancy), 3);
        bus.cmpl_valid  = 1'b1;
        bus.cmpl_idx    = 2'd2;
        bus.alloc_valid = 1'b1;
        bus.alloc_dep   = 4'b0100;
        check("sim_alloc_idx", 32'(bus.alloc_idx), 3);
        tick();
        bus.cmpl_valid  = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_dep   = '0;
        bus.issue_ready = 1'b0;
        check("sim_freed_idx", 32'(bus.alloc_idx), 2);
        check("sim_occupancy_after", 32'(bus.occupancy), 3);
        check("sim_not_yet", 32'(bus.issue_valid), 0);
        tick();
        check("sim_issue_valid", 32'(bus.issue_valid), 1);
        check("sim_issue_idx", 32'(bus.issue_idx), 3);

        // Flush with three valid slots and a held issue
        check("pre_flush_occupancy", 32'(bus.occupancy), 3);
        bus.flush       = 1'b1;
        bus.alloc_valid = 1'b1;
        tick();
        bus.flush       = 1'b0;
        bus.alloc_valid = 1'b0;
        check("flush_occupancy", 32'(bus.occupancy), 0);
        check("flush_issue_valid", 32'(bus.issue_valid), 0);
        check("flush_alloc_idx", 32'(bus.alloc_idx), 0);
        tick();
        check("flush_stays_idle", 32'(bus.issue_valid), 0);

        // Asynchronous reset mid-operation
        bus.alloc_valid = 1'b1;
        repeat (3) tick();
        bus.alloc_valid = 1'b0;
        check("prerst_occupancy", 32'(bus.occupancy), 3);
        check("prerst_issue_valid", 32'(bus.issue_valid), 1);
        check("prerst_issue_idx", 32'(bus.issue_idx), 0);
        bus.issue_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("arst_occupancy", 32'(bus.occupancy), 0);
        check("arst_issue_valid", 32'(bus.issue_valid), 0);
        check("arst_alloc_idx", 32'(bus.alloc_idx), 0);
        @(negedge clk);
        rst = 1'b1;
        bus.issue_ready = 1'b0;
        tick();
        check("post_rst_alloc_ready", 32'(bus.alloc_ready), 1);
        check("post_rst_issue_valid", 32'(bus.issue_valid), 0);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
